// File: rtl/usb_fifo_drain_arb.sv
`default_nettype none
// ============================================================================
// Module      : usb_fifo_drain_arb
// Description : Round-robin drain of endpoint receive FIFOs onto one framed
//               valid/ready byte stream, issuing edge-triggered read pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_fifo_drain_arb #(
    parameter int NUM_EP     = 4,
    parameter int EP_ID_W    = 2,
    parameter int DATA_W     = 8,
    parameter int MAX_BURST  = 64,
    parameter int SETTLE_CYC = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_EP-1:0]        ep_enable,
    input  logic [NUM_EP-1:0]        ep_empty,
    input  logic [16*NUM_EP-1:0]     ep_count,
    input  logic [DATA_W*NUM_EP-1:0] ep_data,
    output logic [NUM_EP-1:0]        ep_rd_en,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_first,
    output logic                     out_last,
    output logic [EP_ID_W-1:0]       out_ep,
    output logic                     busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_OUT     = 3'd3,
        S_SETTLE  = 3'd4
    } state_t;

    localparam logic [15:0]       c_maxBurst   = 16'(MAX_BURST);
    localparam logic [15:0]       c_settleLast = 16'(SETTLE_CYC - 1);
    localparam logic [NUM_EP-1:0] c_oneHot     = NUM_EP'(1);

    state_t               r_state;
    logic [EP_ID_W-1:0]   r_rrPtr;
    logic [15:0]          r_burstLen;
    logic                 r_firstFlag;
    logic [15:0]          r_settleCnt;

    logic [NUM_EP-1:0]    w_elig;
    logic [15:0]          w_countArr [NUM_EP];
    logic [DATA_W-1:0]    w_dataArr  [NUM_EP];
    logic                 w_found;
    logic [EP_ID_W-1:0]   w_grant;
    logic [15:0]          w_selCount;
    logic [DATA_W-1:0]    w_selData;

    function automatic logic [EP_ID_W-1:0] f_wrapIdx(input logic [EP_ID_W-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NUM_EP) s = s - NUM_EP;
        return EP_ID_W'(s);
    endfunction

    generate
        for (genvar i = 0; i < NUM_EP; i++) begin : g_unpack
            assign w_countArr[i] = ep_count[16*i +: 16];
            assign w_dataArr[i]  = ep_data[DATA_W*i +: DATA_W];
            assign w_elig[i]     = ep_enable[i] & ~ep_empty[i] & (ep_count[16*i +: 16] != 16'd0);
        end
    endgenerate

    // First eligible endpoint at or after the round-robin pointer, with wrap
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NUM_EP; k++) begin
            if (!w_found && w_elig[f_wrapIdx(r_rrPtr, k)]) begin
                w_found = 1'b1;
                w_grant = f_wrapIdx(r_rrPtr, k);
            end
        end
    end

    always_comb begin
        w_selCount = '0;
        w_selData  = '0;
        for (int k = 0; k < NUM_EP; k++) begin
            if (EP_ID_W'(k) == w_grant) w_selCount = w_countArr[k];
            if (EP_ID_W'(k) == out_ep)  w_selData  = w_dataArr[k];
        end
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rrPtr     <= '0;
            r_burstLen  <= '0;
            r_firstFlag <= 1'b0;
            r_settleCnt <= '0;
            ep_rd_en    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
            out_ep      <= '0;
        end else begin
            // Read enable is a one-cycle pulse asserted only while in READ
            ep_rd_en <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        ep_rd_en    <= c_oneHot << w_grant;
                        out_ep      <= w_grant;
                        r_rrPtr     <= f_wrapIdx(w_grant, 1);
                        r_burstLen  <= (w_selCount > c_maxBurst) ? c_maxBurst : w_selCount;
                        r_firstFlag <= 1'b1;
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    out_data  <= w_selData;
                    out_valid <= 1'b1;
                    out_first <= r_firstFlag;
                    out_last  <= (r_burstLen == 16'd1);
                    r_state   <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        r_firstFlag <= 1'b0;
                        r_burstLen  <= r_burstLen - 16'd1;
                        if (out_last) begin
                            r_settleCnt <= '0;
                            r_state     <= S_SETTLE;
                        end else begin
                            ep_rd_en <= c_oneHot << out_ep;
                            r_state  <= S_READ;
                        end
                    end
                end
                S_SETTLE: begin
                    // Give the FIFOs' empty/count flags time to catch up
                    if (r_settleCnt == c_settleLast) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_settleCnt <= r_settleCnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/usb_fifo_drain_arb.md
Name: usb_fifo_drain_arb

Overview:
- Round-robin scheduler that drains up to NUM_EP endpoint receive FIFOs onto one byte stream with a valid/ready handshake.
- Sits on the read (rdClk) side of the endpoint FIFOs, clocked by that same clock.
- Generates the FIFOs' edge-triggered read enables. Each FIFO advances only on a rising edge of its read enable and presents data one cycle later.
- Frames each burst with first/last markers and an endpoint id for the downstream packet assembler.

Parameters:
- NUM_EP, 4, number of endpoint FIFOs arbitrated (2..8).
- EP_ID_W, 2, width of endpoint id; must satisfy 2**EP_ID_W >= NUM_EP.
- DATA_W, 8, FIFO data width.
- MAX_BURST, 64, maximum bytes taken from one endpoint per grant (1..65535).
- SETTLE_CYC, 3, idle cycles after a burst before re-arbitration; covers the FIFOs' empty/count update lag.

Ports:
- clk  in  1  rdClk domain clock.
- rst_n  in  1  asynchronous, active-low reset.
- ep_enable  in  NUM_EP  per-endpoint arbitration enable.
- ep_empty  in  NUM_EP  FIFO empty flags.
- ep_count  in  16*NUM_EP  FIFO element counts; endpoint i uses bits [16i+15:16i].
- ep_data  in  DATA_W*NUM_EP  FIFO dataOut buses.
- ep_rd_en  out  NUM_EP  FIFO read enables; at most one bit high, always single-cycle pulses.
- out_data  out  DATA_W  stream byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the byte.
- out_first  out  1  first byte of a burst.
- out_last  out  1  last byte of a burst.
- out_ep  out  EP_ID_W  endpoint id of the current byte.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr = 0.
- Eligibility: endpoint i is eligible when ep_enable[i]=1, ep_empty[i]=0 and ep_count[i] != 0.
- States: IDLE, READ, CAPTURE, OUT, SETTLE.
- IDLE:
  - If any endpoint is eligible, grant the first eligible one searching from rr_ptr upward, with wrap.
  - Latch burst_len = min(ep_count[g], MAX_BURST), a 16-bit unsigned compare.
  - Set out_ep = g, rr_ptr = (g+1) mod NUM_EP, first_flag = 1, then go to READ.
- READ: ep_rd_en[g] = 1 for exactly this cycle, then go to CAPTURE.
- CAPTURE:
  - ep_rd_en = 0.
  - Register out_data <= ep_data[g].
  - out_valid <= 1, out_first <= first_flag, out_last <= (burst_len == 1).
  - Go to OUT.
- OUT:
  - Hold out_data, out_valid, out_first, out_last and out_ep stable until out_ready = 1.
  - On handshake: out_valid <= 0, first_flag <= 0, burst_len <= burst_len - 1.
  - Next state is SETTLE if out_last = 1, otherwise READ.
- SETTLE: stay SETTLE_CYC cycles with no grants, then go to IDLE.
- Throughput: minimum 3 cycles per byte (READ, CAPTURE, OUT with ready already high).
- ep_rd_en is low for at least 2 cycles between pulses, so every pulse produces a fresh rising edge.
- Mid-burst events:
  - ep_count, ep_empty and ep_enable are sampled only in IDLE.
  - Changes during a burst, including ep_enable deassertion, do not shorten it.
  - The granted FIFO is never read more than the latched burst_len times.
- ep_count > MAX_BURST: the remainder is served on a later grant, after the other eligible endpoints.
- Stall: out_ready held low keeps the block in OUT indefinitely; no further read pulses are issued.
- rst_n asserted mid-burst: immediate return to reset values. Unread FIFO data is left in the FIFO; the FIFOs are reset separately.

Test Plan:
- EP1 count = 3 (all others empty), out_ready = 1 → three rd_en[1] pulses 3 cycles apart; bytes D0..D2 on out_ep = 1; first on D0, last on D2; busy returns low after SETTLE_CYC + 1 cycles.
- EP0 count = 2, EP2 count = 2, both enabled → burst EP0 (2 bytes), then burst EP2 (2 bytes). Repeated with rr_ptr = 1 → EP2 is served first.
- EP3 count = 100, MAX_BURST = 64 → first burst is 64 bytes with last on byte 64; then 36 bytes follow on a new grant after SETTLE.
- out_ready low for 10 cycles on byte 2 → out_data, out_first, out_last and out_ep stay stable; no rd_en pulse during the stall; no byte lost or duplicated.
- Single-byte burst (count = 1) → out_first and out_last both high on the same byte; ep_enable[1] = 0 with count = 5 → EP1 is never granted.
- rst_n pulsed low during CAPTURE of a 4-byte burst → all outputs are 0 in the same cycle; after release the block re-arbitrates on the updated counts.
